ecc_decode_ctrl: RTL and testbench

Sequencer for the SECDED (16,11) decode datapath. On `start`, it walks `NUM_WORDS` encoded 16-bit words held as byte pairs in data memory. For each word it computes the syndrome and overall parity, applies the single-bit correction through the MSW/LSW bit-flip lookup, and writes the 11 data bits plus a 2-bit error flag back to memory. It owns the data-memory port for the whole run and reports `done` and per-run error counts.

---
 rtl/ecc_decode_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ecc_decode_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_decode_ctrl.sv
// ecc_decode_ctrl
// ---------------
// Sequencer for a SECDED (16,11) decode pass over data memory. On start it
// reads NUM_WORDS codewords (LSW at SRC_BASE+2k, MSW at +1), computes the
// Hamming syndrome and overall parity, corrects a single-bit error and writes
// the 11 data bits plus a 2-bit error flag to DST_BASE+2k (LSW) and +1 (MSW).
//
// Codeword bit i is Hamming position i: {MSW,LSW} = position 15..0.
//   MSW = {b11,b10,b9,b8,b7,b6,b5,p8}   LSW = {b4,b3,b2,p4,b1,p2,p1,p0}
// Output bytes: MSW = {F1,F0,3'b000,b11,b10,b9}, LSW = {b8..b1}
//   F = 00 clean, 01 corrected (odd overall parity), 10 double error.
//
// Ports
//   Clk, Reset_n     : rising-edge clock, asynchronous active-low reset
//   start            : one-cycle run request, ignored while busy
//   mem_rdata        : read data, valid the cycle after mem_rd_en
//   mem_addr         : byte address, 0 whenever no access is in progress
//   mem_rd_en        : read strobe
//   mem_wr_en        : write strobe, mem_wdata written at mem_addr
//   mem_wdata        : write data
//   busy             : high in every state except IDLE
//   done             : one-cycle pulse in the DONE state
//   corr_cnt/dbl_cnt : per-run counts of F=01 / F=10 words, saturating at 15
//   dbg_state        : current FSM state (IDLE=0 .. DONE=6)
//
// Handshake: there is no back-pressure on the memory port. A read strobe in
// cycle n returns data in cycle n+1; a write strobe commits on the edge that
// ends its cycle. Read and write strobes are never high together.

module ecc_decode_ctrl #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int ADDR_W    = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [3:0]        corr_cnt,
    output logic [3:0]        dbl_cnt,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LSW = 3'd1,
        RD_MSW = 3'd2,
        CHECK  = 3'd3,
        WR_LSW = 3'd4,
        WR_MSW = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [3:0] LAST_K = 4'(NUM_WORDS - 1);

    state_t      state;
    logic [3:0]  k;
    logic [7:0]  lsw_q;
    logic [7:0]  out_msw_q;

    // {idx, hi} is 2*idx + hi, i.e. the byte offset of one half of word idx.
    function automatic logic [ADDR_W-1:0] word_addr(input int base,
                                                    input logic [3:0] idx,
                                                    input logic hi);
        return ADDR_W'(base) + ADDR_W'({idx, hi});
    endfunction

    // ------------------------------------------------------------------
    // Decode datapath. Only meaningful in CHECK, when mem_rdata holds the
    // MSW and lsw_q holds the LSW of the current word.
    // ------------------------------------------------------------------
    logic [15:0] cw;
    logic [3:0]  syn;
    logic        par;
    logic [1:0]  flag;
    logic [7:0]  flip_lsw;
    logic [2:0]  flip_msw;
    logic [10:0] data_raw;
    logic [10:0] data_fix;
    logic [7:0]  out_lsw_d;
    logic [7:0]  out_msw_d;

    assign cw = {mem_rdata, lsw_q};

    // XOR of the indices of all set bits gives {s8,s4,s2,s1} in one pass.
    always_comb begin
        syn = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cw[i]) syn = syn ^ 4'(i);
        end
        par = ^cw;
        if (par)
            flag = 2'b01;
        else if (syn != 4'd0)
            flag = 2'b10;
        else
            flag = 2'b00;
    end

    // Bit-flip lookup: syndromes pointing at parity positions (0,1,2,4,8)
    // leave the data untouched.
    always_comb begin
        flip_lsw = 8'h00;
        case (syn)
            4'd3:    flip_lsw = 8'h01;
            4'd5:    flip_lsw = 8'h02;
            4'd6:    flip_lsw = 8'h04;
            4'd7:    flip_lsw = 8'h08;
            4'd9:    flip_lsw = 8'h10;
            4'd10:   flip_lsw = 8'h20;
            4'd11:   flip_lsw = 8'h40;
            4'd12:   flip_lsw = 8'h80;
            default: flip_lsw = 8'h00;
        endcase
        flip_msw = 3'b000;
        case (syn)
            4'd13:   flip_msw = 3'b001;
            4'd14:   flip_msw = 3'b010;
            4'd15:   flip_msw = 3'b100;
            default: flip_msw = 3'b000;
        endcase
    end

    // Data bits b11..b1 sit at positions 15..9, 7..5 and 3.
    assign data_raw  = {cw[15:9], cw[7:5], cw[3]};
    assign data_fix  = (flag == 2'b01) ? (data_raw ^ {flip_msw, flip_lsw}) : data_raw;
    assign out_lsw_d = data_fix[7:0];
    assign out_msw_d = {flag, 3'b000, data_fix[10:8]};

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Sequencer. Memory strobes, address and data are registered: they are
    // set up on the edge that enters the state that owns them.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            k         <= 4'd0;
            lsw_q     <= 8'h00;
            out_msw_q <= 8'h00;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            corr_cnt  <= 4'd0;
            dbl_cnt   <= 4'd0;
        end else begin
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RD_LSW;
                        k         <= 4'd0;
                        corr_cnt  <= 4'd0;
                        dbl_cnt   <= 4'd0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= word_addr(SRC_BASE, 4'd0, 1'b0);
                    end
                end

                RD_LSW: begin
                    state     <= RD_MSW;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= word_addr(SRC_BASE, k, 1'b1);
                end

                RD_MSW: begin
                    lsw_q <= mem_rdata;
                    state <= CHECK;
                end

                CHECK: begin
                    out_msw_q <= out_msw_d;
                    if (flag == 2'b01 && corr_cnt != 4'd15)
                        corr_cnt <= corr_cnt + 4'd1;
                    if (flag == 2'b10 && dbl_cnt != 4'd15)
                        dbl_cnt <= dbl_cnt + 4'd1;
                    state     <= WR_LSW;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= word_addr(DST_BASE, k, 1'b0);
                    mem_wdata <= out_lsw_d;
                end

                WR_LSW: begin
                    state     <= WR_MSW;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= word_addr(DST_BASE, k, 1'b1);
                    mem_wdata <= out_msw_q;
                end

                WR_MSW: begin
                    k <= k + 4'd1;
                    if (k != LAST_K) begin
                        state     <= RD_LSW;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= word_addr(SRC_BASE, k + 4'd1, 1'b0);
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    // start in this cycle is deliberately not looked at.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_decode_ctrl.sv
// Testbench for ecc_decode_ctrl: byte-wide memory model, Hamming encoder and
// reference decoder built directly from the position/parity definitions,
// directed anchor words plus randomized clean/single/double-error words.

module tb_ecc_decode_ctrl;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int AW  = 8;

    logic          Clk;
    logic          Reset_n;
    logic          start;
    logic [7:0]    mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic [3:0]    corr_cnt;
    logic [3:0]    dbl_cnt;
    logic [2:0]    dbg_state;

    logic [7:0]    mem [0:255];
    logic [7:0]    exp_q [$];
    logic [15:0]   cw_tab [NW];
    int            dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    int            exp_corr;
    int            exp_dbl;
    int            n_cmp = 0;
    int            n_err = 0;
    int            dc;

    ecc_decode_ctrl #(
        .NUM_WORDS (NW),
        .SRC_BASE  (SRC),
        .DST_BASE  (DST),
        .ADDR_W    (AW)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .corr_cnt  (corr_cnt),
        .dbl_cnt   (dbl_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory model ----------------
    always @(posedge Clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Port rule checked every cycle outside reset.
    always @(negedge Clk) begin
        if (Reset_n === 1'b1) begin
            n_cmp++;
            assert (!(mem_rd_en && mem_wr_en) && (mem_rd_en || mem_wr_en || mem_addr == '0))
            else begin
                n_err++;
                $error("FAIL port_rule: rd=%0b wr=%0b addr=0x%0h, required exclusive strobes and addr 0 when idle",
                       mem_rd_en, mem_wr_en, mem_addr);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int          cnt;
        c = 16'h0000;
        for (int j = 0; j < 11; j++) c[dpos[j]] = d[j];
        for (int kb = 0; kb < 4; kb++) begin
            cnt = 0;
            for (int i = 0; i < 16; i++)
                if (((i >> kb) & 1) == 1 && c[i]) cnt++;
            c[1 << kb] = (cnt % 2 == 1);
        end
        c[0] = ($countones(c) % 2 == 1);
        return c;
    endfunction

    function automatic int ref_syn(input logic [15:0] c);
        int s;
        int cnt;
        s = 0;
        for (int kb = 0; kb < 4; kb++) begin
            cnt = 0;
            for (int i = 0; i < 16; i++)
                if (((i >> kb) & 1) == 1 && c[i]) cnt++;
            if (cnt % 2 == 1) s += (1 << kb);
        end
        return s;
    endfunction

    function automatic logic [1:0] ref_flag(input logic [15:0] c);
        if ($countones(c) % 2 == 1) return 2'b01;
        if (ref_syn(c) != 0) return 2'b10;
        return 2'b00;
    endfunction

    // Returns {out_msw, out_lsw}.
    function automatic logic [15:0] ref_out(input logic [15:0] cw);
        logic [15:0] c;
        logic [10:0] d;
        logic [1:0]  f;
        int          s;
        c = cw;
        f = ref_flag(cw);
        s = ref_syn(cw);
        if (f == 2'b01) c[s] = ~c[s];
        for (int j = 0; j < 11; j++) d[j] = c[dpos[j]];
        return {f, 3'b000, d[10:8], d[7:0]};
    endfunction

    function automatic logic [15:0] corrupt(input logic [15:0] cw, input int kind);
        logic [15:0] c;
        int          a;
        int          b;
        c = cw;
        a = 0;
        b = 0;
        if (kind >= 1) begin
            a = $urandom_range(15, 0);
            c[a] = ~c[a];
        end
        if (kind == 2) begin
            b = $urandom_range(14, 0);
            if (b >= a) b++;
            c[b] = ~c[b];
        end
        return c;
    endfunction

    // ---------------- driver / scoreboard tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clk_cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push_expected();
        logic [15:0] o;
        logic [1:0]  f;
        exp_q.delete();
        exp_corr = 0;
        exp_dbl  = 0;
        for (int k = 0; k < NW; k++) begin
            o = ref_out(cw_tab[k]);
            f = ref_flag(cw_tab[k]);
            exp_q.push_back(o[7:0]);
            exp_q.push_back(o[15:8]);
            if (f == 2'b01) exp_corr++;
            if (f == 2'b10) exp_dbl++;
        end
    endtask

    // 5 clean, 5 single-error, 5 double-error words; with directed=1 the
    // first four are the fixed anchor codewords.
    task automatic build_run(input bit directed);
        int          kinds [NW];
        int          lo;
        int          j;
        int          t;
        logic [15:0] dir_cw [4];
        dir_cw = '{16'hFFFF, 16'h2000, 16'hFFFE, 16'h2008};
        if (directed) kinds = '{0, 1, 1, 2, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2};
        else          kinds = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2};
        lo = directed ? 4 : 0;
        for (int i = NW - 1; i > lo; i--) begin
            j = $urandom_range(i, lo);
            t = kinds[i];
            kinds[i] = kinds[j];
            kinds[j] = t;
        end
        for (int k = 0; k < NW; k++) begin
            if (directed && k < 4) cw_tab[k] = dir_cw[k];
            else                   cw_tab[k] = corrupt(encode(11'($urandom)), kinds[k]);
            mem[SRC + 2 * k]     = cw_tab[k][7:0];
            mem[SRC + 2 * k + 1] = cw_tab[k][15:8];
        end
        for (int i = 0; i < 2 * NW; i++) mem[DST + i] = 8'hAA;
        push_expected();
    endtask

    task automatic check_dst(input int nbytes);
        logic [7:0] e;
        for (int i = 0; i < nbytes; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("dst[%0d]", i), mem[DST + i], e);
        end
    endtask

    // Pulses start so it is sampled on edge 0; cycle n follows edge n-1.
    task automatic run_timed(input int budget, input int stray_a, input int stray_b,
                             input bit start_in_done, output int done_cyc);
        int cyc;
        done_cyc = 0;
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget && done_cyc == 0) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (cyc == stray_a || cyc == stray_b) begin
                    chk("busy_mid_run", busy, 1);
                    start = 1'b1;
                end
                clk_cycle();
                start = 1'b0;
                cyc++;
            end
        end
        if (done_cyc != 0) begin
            chk("busy_in_done", busy, 1);
            start = start_in_done;
            clk_cycle();
            start = 1'b0;
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            chk("idle_after_done", dbg_state, 0);
            chk("no_read_after_done", mem_rd_en, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_rd"}, mem_rd_en, 0);
        chk({tag, "_wr"}, mem_wr_en, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_corr"}, corr_cnt, 0);
        chk({tag, "_dbl"}, dbl_cnt, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        // Run 1: anchors + mixed words, stray starts mid-run and in DONE.
        build_run(1'b1);
        run_timed(100, 23, 54, 1'b1, dc);
        chk("run1_done_cycle", dc, 5 * NW + 1);
        chk("run1_corr_cnt", corr_cnt, exp_corr);
        chk("run1_dbl_cnt", dbl_cnt, exp_dbl);
        chk("clean_lsw", mem[DST + 0], 8'hFF);
        chk("clean_msw", mem[DST + 1], 8'h07);
        chk("b9_lsw", mem[DST + 2], 8'h00);
        chk("b9_msw", mem[DST + 3], 8'h40);
        chk("p0_lsw", mem[DST + 4], 8'hFF);
        chk("p0_msw", mem[DST + 5], 8'h47);
        chk("dbl_lsw", mem[DST + 6], 8'h01);
        chk("dbl_msw", mem[DST + 7], 8'h81);
        check_dst(2 * NW);
        repeat (4) clk_cycle();
        chk("corr_hold", corr_cnt, exp_corr);
        chk("dbl_hold", dbl_cnt, exp_dbl);

        // Run 2: reset asserted during WR_LSW of word 3 (cycle 19).
        build_run(1'b0);
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        repeat (18) clk_cycle();
        chk("w3_wr_lsw_strobe", mem_wr_en, 1);
        chk("w3_wr_lsw_addr", mem_addr, DST + 6);
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_dst(6);
        chk("w3_msw_untouched", mem[DST + 7], 8'hAA);
        chk("no_resume", dbg_state, 0);

        // Run 3: fresh start over the same source words reruns from word 0.
        for (int i = 0; i < 2 * NW; i++) mem[DST + i] = 8'hAA;
        push_expected();
        run_timed(100, 0, 0, 1'b0, dc);
        chk("run3_done_cycle", dc, 5 * NW + 1);
        chk("run3_corr_cnt", corr_cnt, exp_corr);
        chk("run3_dbl_cnt", dbl_cnt, exp_dbl);
        check_dst(2 * NW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
